// File: rtl/control_barrera.sv
// Single-lane parking barrier controller.
// Arbitrates entry/exit requests and times the open/close phases.
module control_barrera #(
  parameter int N         = 3,
  parameter int T_ABIERTA = 3000,
  parameter int T_CIERRE  = 1000,
  parameter int W_T       = 12
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         TICK,
  input  logic         REQ_IN,
  input  logic         REQ_OUT,
  input  logic         PASO,
  input  logic [N-1:0] OCUP,
  input  logic         LLENO,
  output logic         ABRIR,
  output logic         DIR,
  output logic         INC,
  output logic         DEC,
  output logic         RECHAZO,
  output logic         TIMEOUT,
  output logic         OCUPADO
);

  typedef enum logic [1:0] {
    IDLE,
    ABRE_ENT,
    ABRE_SAL,
    CIERRE
  } state_t;

  localparam logic [W_T-1:0] TA_LAST = W_T'(T_ABIERTA - 1);
  localparam logic [W_T-1:0] TC_LAST = W_T'(T_CIERRE - 1);
  localparam logic [W_T-1:0] T_ONE   = W_T'(1);

  state_t         state, state_n;
  logic [W_T-1:0] timer, timer_n;
  logic           pend_in, pend_out;
  logic           last_dir, last_dir_n;
  logic           req_in_q, req_out_q, paso_q;

  logic in_rise, out_rise, paso_rise;
  logic pin_clr, pout_clr;
  logic in_v, out_v;
  logic abrir_n, dir_n, inc_n, dec_n;
  logic rech_n, tout_n, ocup_n;

  assign in_rise   = REQ_IN & ~req_in_q;
  assign out_rise  = REQ_OUT & ~req_out_q;
  assign paso_rise = PASO & ~paso_q;

  // Edge-detect history for the level inputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      req_in_q  <= 1'b0;
      req_out_q <= 1'b0;
      paso_q    <= 1'b0;
    end else begin
      req_in_q  <= REQ_IN;
      req_out_q <= REQ_OUT;
      paso_q    <= PASO;
    end
  end

  // Next-state, timer, arbitration and registered output values.
  always_comb begin
    state_n    = state;
    timer_n    = timer;
    last_dir_n = last_dir;
    dir_n      = DIR;
    pin_clr    = 1'b0;
    pout_clr   = 1'b0;
    inc_n      = 1'b0;
    dec_n      = 1'b0;
    rech_n     = 1'b0;
    tout_n     = 1'b0;
    in_v       = pend_in & ~LLENO;
    out_v      = pend_out & (OCUP != '0);
    unique case (state)
      IDLE: begin
        if (pend_in && LLENO) begin
          rech_n  = 1'b1;
          pin_clr = 1'b1;
        end
        if (pend_out && (OCUP == '0)) begin
          pout_clr = 1'b1;
        end
        if (in_v && (!out_v || last_dir)) begin
          state_n    = ABRE_ENT;
          dir_n      = 1'b0;
          pin_clr    = 1'b1;
          last_dir_n = 1'b0;
          timer_n    = '0;
        end else if (out_v) begin
          state_n    = ABRE_SAL;
          dir_n      = 1'b1;
          pout_clr   = 1'b1;
          last_dir_n = 1'b1;
          timer_n    = '0;
        end
      end
      ABRE_ENT, ABRE_SAL: begin
        if (paso_rise) begin
          inc_n   = (state == ABRE_ENT);
          dec_n   = (state == ABRE_SAL);
          state_n = CIERRE;
          timer_n = '0;
        end else if (TICK) begin
          if (timer == TA_LAST) begin
            tout_n  = 1'b1;
            state_n = CIERRE;
            timer_n = '0;
          end else begin
            timer_n = timer + T_ONE;
          end
        end
      end
      CIERRE: begin
        if (TICK) begin
          if (timer == TC_LAST) begin
            state_n = IDLE;
            timer_n = '0;
          end else begin
            timer_n = timer + T_ONE;
          end
        end
      end
      default: begin
        state_n = IDLE;
        timer_n = '0;
      end
    endcase
    abrir_n = (state_n == ABRE_ENT) || (state_n == ABRE_SAL);
    ocup_n  = (state_n != IDLE);
  end

  // State, pending flags and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      timer    <= '0;
      pend_in  <= 1'b0;
      pend_out <= 1'b0;
      last_dir <= 1'b1;
      ABRIR    <= 1'b0;
      DIR      <= 1'b0;
      INC      <= 1'b0;
      DEC      <= 1'b0;
      RECHAZO  <= 1'b0;
      TIMEOUT  <= 1'b0;
      OCUPADO  <= 1'b0;
    end else begin
      state    <= state_n;
      timer    <= timer_n;
      pend_in  <= (pend_in & ~pin_clr) | in_rise;
      pend_out <= (pend_out & ~pout_clr) | out_rise;
      last_dir <= last_dir_n;
      ABRIR    <= abrir_n;
      DIR      <= dir_n;
      INC      <= inc_n;
      DEC      <= dec_n;
      RECHAZO  <= rech_n;
      TIMEOUT  <= tout_n;
      OCUPADO  <= ocup_n;
    end
  end

endmodule
